fwrisc_regfile_dbg_arb: RTL and testbench

//  Shares the register file's RB read port and RD write port between the core and a debug access port.
//  - Covers GPRs and CSRs, 6-bit address space.
//  - Sits between the decode/execute stage and the register file.
//  - Grants debug only when the core is not using the register file, or after a starvation limit.
//  - While debug owns the ports, the core is stalled.

---
 rtl/fwrisc_regfile_dbg_arb.sv | 125 ++++++++++++
 tb/tb_fwrisc_regfile_dbg_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_regfile_dbg_arb.sv
// Arbitrates the register-file RB read port and RD write port between the core
// and a 4-phase debug access port; the core is stalled while debug owns the ports.
module fwrisc_regfile_dbg_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  core_ra_raddr,
  input  logic [5:0]  core_rb_raddr,
  input  logic [5:0]  core_rd_waddr,
  input  logic [31:0] core_rd_wdata,
  input  logic        core_rd_wen,
  input  logic        core_rf_busy,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [5:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [5:0]  ra_raddr,
  output logic [5:0]  rb_raddr,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  input  logic [31:0] rb_rdata
);

  // A zero limit still needs a one-bit counter so the compare stays legal.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GRANT = 3'd2,
    S_READ  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_hold_we;
  logic [5:0]       r_hold_addr;
  logic [31:0]      r_hold_wdata;
  logic [31:0]      r_dbg_rdata;
  logic             w_starved;
  logic             w_dbg_owns;

  assign w_starved  = (r_starve_cnt == LIMIT_C);
  assign w_dbg_owns = (r_state == S_GRANT) || (r_state == S_READ);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Hold registers, starvation counter and captured read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dbg_req) begin
            r_hold_we    <= dbg_we;
            r_hold_addr  <= dbg_addr;
            r_hold_wdata <= dbg_wdata;
            r_starve_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (core_rf_busy && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        S_READ: begin
          r_dbg_rdata <= rb_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (dbg_req) w_next = S_WAIT;
      S_WAIT:  if (!core_rf_busy || w_starved) w_next = S_GRANT;
      S_GRANT: w_next = r_hold_we ? S_ACK : S_READ;
      S_READ:  w_next = S_ACK;
      S_ACK:   if (!dbg_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Core passthrough unless debug owns the ports; core writes never leak into GRANT/READ.
  always_comb begin
    ra_raddr   = core_ra_raddr;
    rb_raddr   = core_rb_raddr;
    rd_waddr   = core_rd_waddr;
    rd_wdata   = core_rd_wdata;
    rd_wen     = core_rd_wen;
    core_stall = 1'b0;
    if (w_dbg_owns) begin
      rb_raddr   = r_hold_addr;
      rd_waddr   = r_hold_addr;
      rd_wdata   = r_hold_wdata;
      rd_wen     = (r_state == S_GRANT) && r_hold_we;
      core_stall = 1'b1;
    end
  end

  assign dbg_ack   = (r_state == S_ACK);
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_fwrisc_regfile_dbg_arb.sv
// Bench for fwrisc_regfile_dbg_arb: directed vector table, hand-written corner
// sequences and randomized accesses against a timeline/register-file model.
module tb_fwrisc_regfile_dbg_arb;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  core_ra_raddr, core_rb_raddr, core_rd_waddr;
  logic [31:0] core_rd_wdata;
  logic        core_rd_wen, core_rf_busy, core_stall;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
  logic [31:0] rd_wdata, rb_rdata;
  logic        rd_wen;

  always #5 clock = ~clock;

  fwrisc_regfile_dbg_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
    .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
    .core_rd_wen(core_rd_wen), .core_rf_busy(core_rf_busy), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ra_raddr(ra_raddr), .rb_raddr(rb_raddr), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .rb_rdata(rb_rdata)
  );

  // Register file environment: r0 reads 0 and ignores writes, 1-cycle read latency.
  logic [31:0] mem [64] = '{default: 32'h0};
  always @(posedge clock) begin
    if (rd_wen && rd_waddr != 6'd0) mem[rd_waddr] <= rd_wdata;
    rb_rdata <= (rb_raddr == 6'd0) ? 32'h0 : mem[rb_raddr];
  end

  logic [31:0] exp_mem [64] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_core();
    core_rd_wen  = 1'b0;
    core_rf_busy = 1'b0;
    core_ra_raddr = 6'd0;
    core_rb_raddr = 6'd0;
    core_rd_waddr = 6'd0;
    core_rd_wdata = 32'h0;
  endtask

  // One debug access. Cycle 0 is the cycle req is first presented. The model
  // finds the last WAIT cycle from the busy pattern, then GRANT (and READ)
  // follow and ack arrives one cycle later.
  task automatic run_access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                            input int busy_n, input bit rnd, input int hold_n,
                            output int lat, output logic [31:0] rdata);
    bit busy [48];
    int w, g, ack_c;
    bit stall_e;
    bit dbg_wr_e;
    logic [31:0] exp_rd;
    for (int c = 0; c < 48; c++)
      busy[c] = rnd ? 1'($urandom_range(0, 1)) : (c >= 1 && c <= busy_n);
    w = -1;
    for (int c = 1; c < 48 && w < 0; c++)
      if (!busy[c] || (c - 1) == LIMIT) w = c;
    g = w + 1;
    ack_c = we ? g + 1 : g + 2;
    lat = -1;
    rdata = 32'h0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (c > 0) begin
        dbg_we = 1'($urandom); dbg_addr = 6'($urandom); dbg_wdata = $urandom;
      end
      core_rf_busy  = busy[c];
      core_ra_raddr = 6'($urandom);
      core_rb_raddr = 6'($urandom);
      core_rd_wdata = $urandom;
      if (rnd) begin
        core_rd_wen   = 1'($urandom);
        core_rd_waddr = 6'($urandom);
      end else begin
        core_rd_wen   = (c == 0) || (c == g);
        core_rd_waddr = (c == 0) ? 6'd40 : addr;
      end
      @(negedge clock);
      stall_e  = (c == g) || (!we && c == g + 1);
      dbg_wr_e = we && (c == g);
      chk("core_stall", core_stall, stall_e);
      chk("ra_raddr", ra_raddr, core_ra_raddr);
      if (stall_e) begin
        chk("rd_wen_dbg", rd_wen, dbg_wr_e);
        chk("rb_raddr_dbg", rb_raddr, addr);
        if (dbg_wr_e) begin
          chk("rd_waddr_dbg", rd_waddr, addr);
          chk("rd_wdata_dbg", rd_wdata, wdata);
        end
      end else begin
        chk("rd_wen_core", rd_wen, core_rd_wen);
        chk("rb_raddr_core", rb_raddr, core_rb_raddr);
        if (core_rd_wen) begin
          chk("rd_waddr_core", rd_waddr, core_rd_waddr);
          chk("rd_wdata_core", rd_wdata, core_rd_wdata);
        end
      end
      chk("dbg_ack", dbg_ack, c == ack_c);
      if (dbg_ack) begin
        lat = c;
        rdata = dbg_rdata;
        if (!we) begin
          exp_rd = (addr == 6'd0) ? 32'h0 : exp_mem[addr];
          chk("dbg_rdata", dbg_rdata, exp_rd);
          last_rd = exp_rd;
        end else begin
          chk("rdata_hold", dbg_rdata, last_rd);
        end
      end
      if (!stall_e && core_rd_wen && core_rd_waddr != 6'd0) exp_mem[core_rd_waddr] = core_rd_wdata;
      if (dbg_wr_e && addr != 6'd0) exp_mem[addr] = wdata;
      step();
    end
    if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    quiet_core();
    for (int h = 0; h < hold_n; h++) begin
      dbg_req = 1'b1;
      @(negedge clock);
      chk("ack_held", dbg_ack, 1'b1);
      chk("stall_after_ack", core_stall, 1'b0);
      chk("no_second_write", rd_wen, 1'b0);
      step();
    end
    dbg_req = 1'b0;
    @(negedge clock);
    chk("ack_until_drop", dbg_ack, 1'b1);
    step();
    @(negedge clock);
    chk("ack_released", dbg_ack, 1'b0);
    chk("stall_released", core_stall, 1'b0);
    step();
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          busy_n;
    int          hold_n;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int lat;
    logic [31:0] rd;
    bit ack_e, stall_e;

    tbl[0] = '{1'b1, 6'd5,  32'hDEADBEEF, 0,  0, 3,  32'h0};
    tbl[1] = '{1'b0, 6'd5,  32'h0,        0,  0, 4,  32'hDEADBEEF};
    tbl[2] = '{1'b0, 6'd5,  32'h0,        20, 0, 12, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 6'd7,  32'hCAFEF00D, 3,  0, 6,  32'hDEADBEEF};
    tbl[4] = '{1'b1, 6'd0,  32'h00001234, 0,  0, 3,  32'hDEADBEEF};
    tbl[5] = '{1'b0, 6'd0,  32'h0,        0,  0, 4,  32'h0};
    tbl[6] = '{1'b1, 6'h3F, 32'hA5A50001, 0,  5, 3,  32'h0};
    tbl[7] = '{1'b0, 6'h3F, 32'h0,        8,  0, 12, 32'hA5A50001};
    tbl[8] = '{1'b0, 6'd7,  32'h0,        1,  2, 5,  32'hCAFEF00D};

    reset = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 6'd0; dbg_wdata = 32'h0;
    quiet_core();
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_rd_wen", rd_wen, 1'b0);
    step();

    for (int i = 0; i < 9; i++) begin
      run_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].busy_n, 1'b0, tbl[i].hold_n, lat, rd);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
    end

    // Request dropped before ack: access still completes, ACK leaves next cycle.
    for (int c = 0; c < 5; c++) begin
      dbg_req = (c == 0); dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h55AA55AA;
      @(negedge clock);
      ack_e = (c == 3);
      stall_e = (c == 2);
      chk("early_drop_ack", dbg_ack, ack_e);
      chk("early_drop_stall", core_stall, stall_e);
      chk("early_drop_wen", rd_wen, stall_e);
      step();
    end
    exp_mem[9] = 32'h55AA55AA;

    // Reset while in READ aborts the access and clears the captured data.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
    for (int c = 0; c < 3; c++) step();
    @(negedge clock);
    chk("in_read_stall", core_stall, 1'b1);
    chk("in_read_rdata_prev", dbg_rdata, 32'hCAFEF00D);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dbg_req = 1'b0;
    @(negedge clock);
    chk("rst_read_ack", dbg_ack, 1'b0);
    chk("rst_read_stall", core_stall, 1'b0);
    chk("rst_read_rdata", dbg_rdata, 32'h0);
    chk("rst_read_wen", rd_wen, 1'b0);
    step();
    @(negedge clock);
    chk("rst_read_idle_ack", dbg_ack, 1'b0);
    chk("rst_read_idle_wen", rd_wen, 1'b0);
    last_rd = 32'h0;
    step();

    for (int i = 0; i < 30; i++) begin
      run_access(1'($urandom), 6'($urandom), $urandom, 0, 1'b1, $urandom_range(0, 2), lat, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
